// File: rtl/adder_pipe_nb.sv
// Pipelined WIDTH-bit ripple-carry adder, one WIDTH/STAGES-bit slice per stage, valid/ready flow.
// Define ADDER_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module adder_pipe_nb #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SLICE = WIDTH / STAGES;

    function automatic logic [SLICE:0] ripple(input logic [SLICE-1:0] x,
                                              input logic [SLICE-1:0] y,
                                              input logic             c);
        logic [SLICE-1:0] s;
        logic             cy;
        s  = '0;
        cy = c;
        for (int unsigned i = 0; i < SLICE; i++) begin
            s[i] = x[i] ^ y[i] ^ cy;
            cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
        end
        return {cy, s};
    endfunction

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES:0]   ready;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];

    // ready_k = !valid_k || ready_{k+1}, unrolled so no bit depends on another bit of ready.
    always_comb begin
        logic full;
        full          = 1'b1;
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
            full = 1'b1;
            for (int unsigned j = k; j < STAGES; j++) begin
                full = full & valid_q[j];
            end
            ready[k] = out_ready | ~full;
        end
    end

    always_comb begin
        logic [WIDTH-1:0] src_a, src_b, src_s;
        logic             src_c;
        logic [SLICE:0]   slice_r;
        int unsigned      prev;
        src_a   = '0;
        src_b   = '0;
        src_s   = '0;
        src_c   = 1'b0;
        slice_r = '0;
        prev    = 0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            prev       = (k == 0) ? 0 : k - 1;
            src_a      = a;
            src_b      = b;
            src_s      = '0;
            src_c      = cin;
            valid_d[k] = in_valid;
            if (k > 0) begin
                src_a      = opa_q[prev];
                src_b      = opb_q[prev];
                src_s      = sum_q[prev];
                src_c      = carry_q[prev];
                valid_d[k] = valid_q[prev];
            end
            slice_r  = ripple(src_a[k*SLICE +: SLICE], src_b[k*SLICE +: SLICE], src_c);
            sum_d[k] = src_s;
            sum_d[k][k*SLICE +: SLICE] = slice_r[SLICE-1:0];
            carry_d[k] = slice_r[SLICE];
            opa_d[k]   = src_a;
            opb_d[k]   = src_b;
        end
    end

    // Payload only moves with a valid token; bubbles leave stale data masked by valid_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_d[k];
                    if (valid_d[k]) begin
                        sum_q[k]   <= sum_d[k];
                        carry_q[k] <= carry_d[k];
                        opa_q[k]   <= opa_d[k];
                        opb_q[k]   <= opb_d[k];
                    end
                end
            end
        end
    end

`ifdef ADDER_PIPE_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d = (opa_d[STAGES-1][WIDTH-1] == opb_d[STAGES-1][WIDTH-1]) &&
                   (sum_d[STAGES-1][WIDTH-1] != opa_d[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (ready[STAGES-1] && valid_d[STAGES-1]) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];

endmodule

// File: tb/tb_adder_pipe_nb.sv
// Self-checking bench for adder_pipe_nb: 16-bit/4-stage instance plus a 4-bit/1-stage instance,
// checked against an arithmetic reference model and an in-order expectation queue.
module tb_adder_pipe_nb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [15:0] a, b, sum;
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_cin, d_cout;
    logic [3:0]  d_a, d_b, d_sum;
`ifdef ADDER_PIPE_OVF_EN
    logic        ovf, d_ovf;
`endif

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    logic [17:0] exp_q[$];
    logic [17:0] out_word, exp_w;
    logic        in_fire, out_fire;

    always #5 clk = ~clk;

    adder_pipe_nb #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    adder_pipe_nb #(.WIDTH(4), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b),
        .cin(d_cin), .out_valid(d_out_valid), .out_ready(d_out_ready), .sum(d_sum), .cout(d_cout)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(d_ovf)
`endif
    );

    // Expected {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
        int          t, st;
        logic [17:0] r;
        t       = int'(x) + int'(y) + int'(c);
        st      = int'($signed(x)) + int'($signed(y)) + int'(c);
        r[16:0] = t[16:0];
        r[17]   = (st > 32767) || (st < -32768);
`ifndef ADDER_PIPE_OVF_EN
        r[17] = 1'b0;
`endif
        return r;
    endfunction

    task automatic tick();
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        out_word = {1'b0, cout, sum};
`ifdef ADDER_PIPE_OVF_EN
        out_word[17] = ovf;
`endif
        if (in_fire) exp_q.push_back(model(a, b, cin));
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if ({cout, sum} !== 17'h0) begin n_err++; $display("FAIL reset_sum got %h want 0", {cout, sum}); end
`ifdef ADDER_PIPE_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int e = 0; e < 4; e++) begin
            if (e > 0) begin @(posedge clk); @(negedge clk); end
            n_checks++;
            if (e < 3) begin
                if (out_valid !== 1'b0) begin
                    n_err++; $display("FAIL single_early edge=%0d out_valid=%b want 0", e, out_valid);
                end
            end else if ({out_valid, cout, sum} !== {1'b1, 1'b1, 16'h0000}) begin
                n_err++;
                $display("FAIL single_result got v=%b c=%b s=%h want v=1 c=1 s=0000", out_valid, cout, sum);
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_dup out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        int n_out = 0, first = -1, last = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 28; i++) begin
            in_valid = (i < 8);
            a = 16'(i * 32'h1111); b = 16'h0101; cin = i[0];
            if (i >= 8 && exp_q.size() == 0) break;
            tick();
            if (i < 8) begin
                n_checks++;
                if (in_fire !== 1'b1) begin n_err++; $display("FAIL stream_in_ready i=%0d got 0 want 1", i); end
            end
            if (out_fire) begin
                n_checks++;
                exp_w = 'x;
                if (exp_q.size() > 0) exp_w = exp_q.pop_front();
                if (out_word !== exp_w) begin n_err++; $display("FAIL stream_data got %h want %h", out_word, exp_w); end
                n_out++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        n_checks++;
        if (n_out != 8) begin n_err++; $display("FAIL stream_count got %0d want 8", n_out); end
        n_checks++;
        if (last - first != 7) begin n_err++; $display("FAIL stream_gaps span got %0d want 7", last - first); end
    endtask

    task automatic test_backpressure();
        int          acc = 0;
        logic        have = 1'b0;
        logic [16:0] held = '0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            tick();
            if (in_fire) acc++;
            if (out_valid && !have) begin have = 1'b1; held = {cout, sum}; end
            else if (have) begin
                n_checks++;
                if ({cout, sum} !== held) begin n_err++; $display("FAIL bp_hold got %h want %h", {cout, sum}, held); end
            end
        end
        #1;
        n_checks++;
        if (acc != 4) begin n_err++; $display("FAIL bp_accepted got %0d want 4", acc); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            tick();
            n_checks++;
            if (!(in_fire && out_fire)) begin
                n_err++; $display("FAIL bp_simul in=%b out=%b want 1 1", in_fire, out_fire);
            end
            if (out_fire) begin
                n_checks++;
                exp_w = 'x;
                if (exp_q.size() > 0) exp_w = exp_q.pop_front();
                if (out_word !== exp_w) begin n_err++; $display("FAIL bp_data got %h want %h", out_word, exp_w); end
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            tick();
            if (out_fire) begin
                n_checks++;
                exp_w = exp_q.pop_front();
                if (out_word !== exp_w) begin n_err++; $display("FAIL bp_drain got %h want %h", out_word, exp_w); end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain_timeout left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, cout, sum} !== 18'h0) begin
            n_err++; $display("FAIL rstmid_outputs got v=%b c=%b s=%h want all 0", out_valid, cout, sum);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        a = 16'h0003; b = 16'h0004; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_fire) begin
                n++;
                n_checks++;
                if (out_word !== 18'h00008) begin n_err++; $display("FAIL rstmid_sum got %h want 00008", out_word); end
            end
        end
        n_checks++;
        if (n != 1) begin n_err++; $display("FAIL rstmid_count got %0d want 1", n); end
    endtask

`ifdef ADDER_PIPE_OVF_EN
    task automatic test_overflow();
        logic [17:0] want;
        int          n = 0;
        out_ready = 1'b1;
        cin       = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 3);
            case (i)
                0:       begin a = 16'h7FFF; b = 16'h0001; end
                1:       begin a = 16'h8000; b = 16'h8000; end
                default: begin a = 16'h0005; b = 16'h0004; end
            endcase
            tick();
            if (out_fire) begin
                case (n)
                    0:       want = {1'b1, 1'b0, 16'h8000};
                    1:       want = {1'b1, 1'b1, 16'h0000};
                    default: want = {1'b0, 1'b0, 16'h0009};
                endcase
                n_checks++;
                if (out_word !== want) begin n_err++; $display("FAIL ovf_case%0d got %h want %h", n, out_word, want); end
                n++;
            end
        end
        exp_q.delete();
        n_checks++;
        if (n != 3) begin n_err++; $display("FAIL ovf_count got %0d want 3", n); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            tick();
            if (out_fire) begin
                n_checks++;
                exp_w = 'x;
                if (exp_q.size() > 0) exp_w = exp_q.pop_front();
                if (out_word !== exp_w) begin n_err++; $display("FAIL rand_data got %h want %h", out_word, exp_w); end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            tick();
            if (out_fire) begin
                n_checks++;
                exp_w = exp_q.pop_front();
                if (out_word !== exp_w) begin n_err++; $display("FAIL rand_drain got %h want %h", out_word, exp_w); end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_drain_timeout left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_degenerate();
        int t, st;
        d_out_ready = 1'b1;
        d_a = 4'hF; d_b = 4'hF; d_cin = 1'b1; d_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({d_out_valid, d_cout, d_sum} !== 6'b1_1_1111) begin
            n_err++; $display("FAIL deg_ff got v=%b c=%b s=%h want v=1 c=1 s=f", d_out_valid, d_cout, d_sum);
        end
        for (int i = 0; i < 30; i++) begin
            d_a = 4'($urandom); d_b = 4'($urandom); d_cin = 1'($urandom);
            t  = int'(d_a) + int'(d_b) + int'(d_cin);
            st = int'($signed(d_a)) + int'($signed(d_b)) + int'(d_cin);
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({d_out_valid, d_cout, d_sum} !== {1'b1, t[4:0]}) begin
                n_err++; $display("FAIL deg_rand got v=%b %h want v=1 %h", d_out_valid, {d_cout, d_sum}, t[4:0]);
            end
`ifdef ADDER_PIPE_OVF_EN
            n_checks++;
            if (d_ovf !== ((st > 7) || (st < -8))) begin
                n_err++; $display("FAIL deg_ovf got %b want %b", d_ovf, (st > 7) || (st < -8));
            end
`endif
        end
        d_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        d_in_valid = 1'b0; d_out_ready = 1'b1; d_a = '0; d_b = '0; d_cin = 1'b0;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_reset_mid();
`ifdef ADDER_PIPE_OVF_EN
        test_overflow();
`endif
        test_random();
        test_degenerate();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
